// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM encoding and next-PC select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_HOLD   = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: branch over jump over stall over sequential fetch.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic        active,
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic [31:0] pc_next,
    output pc_sel_e     sel
);

    always_comb begin
        sel     = SEL_HOLD;
        pc_next = pc;
        if (active) begin
            // Branch belongs to the older instruction, so it outranks the jump.
            if (branch_taken) begin
                sel     = SEL_BRANCH;
                pc_next = word_align(branch_target);
            end else if (jump_taken) begin
                sel     = SEL_JUMP;
                pc_next = word_align(jump_target);
            end else if (!stall) begin
                sel     = SEL_SEQ;
                pc_next = pc + 32'(WORD_BYTES);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] FetchCount
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcp4_q, pcp4_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;

    logic [31:0]  pc_next;
    pc_sel_e      pc_sel;

    pc_next_sel u_pc_next_sel (
        .active        (state_q != ST_BOOT),
        .pc            (pc_q),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .jump_taken    (JumpTaken),
        .jump_target   (JumpTarget),
        .stall         (Stall),
        .pc_next       (pc_next),
        .sel           (pc_sel)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else begin
            // RUN and REDIRECT share identical datapath behaviour.
            state_d = ST_RUN;
            pc_d    = pc_next;
            unique case (pc_sel)
                SEL_BRANCH, SEL_JUMP: begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_REDIRECT;
                end
                SEL_SEQ: begin
                    instr_d = IMemData;
                    pcp4_d  = pc_next;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= word_align(RESET_PC);
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign IMemAddr          = pc_q;
    assign PC                = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pcp4_q;
    assign IF_ID_Valid       = valid_q;
    assign FetchCount        = count_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the MIPS datapath, sitting directly upstream of the opcode decoder/controller. It owns the program counter, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register whose `[31:26]` field feeds the controller. It handles sequential fetch, branch/jump redirection with a one-slot bubble, decode-stage stalls, and a post-reset boot cycle.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hazard unit holds PC and IF/ID.
- `BranchTaken`  in  1  branch resolved taken this cycle.
- `BranchTarget`  in  32  branch destination.
- `JumpTaken`  in  1  jump decoded this cycle.
- `JumpTarget`  in  32  jump destination.
- `IMemAddr`  out  32  instruction memory address; equals `PC`.
- `IMemData`  in  32  instruction word, combinational read of `IMemAddr`.
- `PC`  out  32  current fetch PC.
- `IF_ID_Instruction`  out  32  registered instruction to decoder.
- `IF_ID_PCPlus4`  out  32  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction.
- `FetchCount`  out  32  count of instructions loaded into IF/ID with valid=1.

## Operation
- FSM states: BOOT, RUN, REDIRECT.
- Reset (async): state=BOOT, PC=RESET_PC, IF_ID_Instruction=32'h0 (NOP), IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0.
- BOOT: one cycle; PC held, IF/ID stays bubble; next state RUN. Stall and redirect inputs are ignored in BOOT.
- RUN, per edge, priority high to low:
  - BranchTaken: PC<=BranchTarget & ~3; IF/ID<=bubble (instr 0, valid 0); state REDIRECT.
  - JumpTaken: PC<=JumpTarget & ~3; IF/ID<=bubble; state REDIRECT.
  - Stall: PC, IF/ID, FetchCount held; stay RUN.
  - Otherwise: IF_ID_Instruction<=IMemData, IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1, PC<=PC+4, FetchCount+=1.
- REDIRECT: one-cycle state marking the first fetch from the new target. It behaves exactly as RUN, including redirect and stall priority, then goes to RUN unless a new redirect occurs.
- BranchTaken and JumpTaken together: branch wins because it belongs to the older instruction.
- Redirect beats Stall: the stalled instruction is squashed.
- Arithmetic is modulo 2^32. PC 32'hFFFF_FFFC+4 wraps to 0. FetchCount wraps to 0.
- Target bits [1:0] are always forced to 0.

## Timing
- `IMemAddr` is a combinational copy of `PC`. `IMemData` must settle within the same cycle.
- Fetch-to-decode latency: 1 cycle. The word at PC appears on IF_ID_* after the next rising edge.
- Redirect penalty: 1 bubble. The target instruction reaches IF/ID two edges after the redirect edge.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock edge. First valid IF/ID occurs on the second edge after reset release (BOOT, then fetch).
- All outputs except `IMemAddr` are registered.

## Structure
- Shared package `mips_pkg`: opcode constants (R-type, lw, sw, beq, bne, j, jal, …), `NOP_INSTR` = 32'h0, FSM state encoding for BOOT/RUN/REDIRECT, `WORD_BYTES` = 4.
- One sub-module, `pc_next_sel`: a combinational next-PC mux over {PC+4, branch, jump, hold} with the priority above. The FSM and registers stay in `instruction_fetch`.

## Test plan
- Reset release, RESET_PC=0, memory word at address `n` = n+1, no stalls.
  - Edge 1 (BOOT): IF_ID_Valid=0.
  - Edge 2: IF_ID_Instruction=1, IF_ID_PCPlus4=4.
  - Edge 3: IF_ID_Instruction=2, PC=8, FetchCount=2.
- Stall asserted for 3 cycles at PC=0x10: PC stays 0x10, IF/ID unchanged, FetchCount unchanged. On release the next edge loads word @0x10 and PC becomes 0x14.
- BranchTaken with BranchTarget=0x43 at PC=0x20:
  - Next edge: PC=0x40, IF_ID_Valid=0, IF_ID_Instruction=0.
  - Following edge: IF_ID_PCPlus4=0x44, valid=1.
- BranchTaken (0x100), JumpTaken (0x200) and Stall all asserted together: PC=0x100, IF/ID bubble.
- PC preset to 0xFFFF_FFFC with no stall: after the edge, PC=0 and IF_ID_PCPlus4=0.
- Reset asserted asynchronously mid-cycle while in REDIRECT: all outputs return to reset values immediately, without a clock edge. After release the sequence repeats the first scenario.
